// File: rtl/sw_debounce_pkg.sv
// Shared constants and helpers for the slide-switch debouncer.
package sw_debounce_pkg;
  localparam int DEBOUNCE_CNT_100MHZ_10MS = 1000000;
  localparam int SIM_CNT_MAX              = 4;

  // The counter only has to reach CNT_MAX-1, so $clog2(CNT_MAX) bits are enough.
  function automatic int cnt_width(input int cnt_max);
    return (cnt_max < 2) ? 1 : $clog2(cnt_max);
  endfunction
endpackage

// File: rtl/sw_debounce_if.sv
// Switch bundle between the raw pins and the debouncer. The master side drives the pins.
interface sw_debounce_if #(
  parameter int WIDTH = 2
);
  logic [WIDTH-1:0] sw_raw;
  logic [WIDTH-1:0] sw_clean;
  logic [WIDTH-1:0] sw_rise;
  logic [WIDTH-1:0] sw_fall;
  logic             sw_changed;
  logic             stable;

  modport master (output sw_raw, input sw_clean, input sw_rise, input sw_fall,
                  input sw_changed, input stable);
  modport slave  (input sw_raw, output sw_clean, output sw_rise, output sw_fall,
                  output sw_changed, output stable);
endinterface

// File: rtl/sw_debounce_bit.sv
// One switch bit: synchroniser, stability counter, clean bit and edge strobes.
// A change is accepted SYNC_STAGES+CNT_MAX-1 edges after first sampling; there is no backpressure.
module debounce_bit
  import sw_debounce_pkg::*;
#(
  parameter int   CNT_MAX     = DEBOUNCE_CNT_100MHZ_10MS,
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_BIT     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_sw_raw,
  output logic o_clean,
  output logic o_rise,
  output logic o_fall,
  output logic o_cnt_zero
);
  localparam int            CW       = cnt_width(CNT_MAX);
  localparam logic [CW-1:0] CNT_LAST = CW'(CNT_MAX - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CW-1:0]          r_cnt;
  logic                   r_clean;
  logic                   r_rise;
  logic                   r_fall;
  logic                   w_sync_q;

  assign w_sync_q = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_sync <= {SYNC_STAGES{RST_BIT}};
    else     r_sync <= {r_sync[SYNC_STAGES-2:0], i_sw_raw};
  end

  // Any sample agreeing with the clean value restarts the count, so bounce never accumulates.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_clean <= RST_BIT;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      if (w_sync_q == r_clean) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_cnt   <= '0;
        r_clean <= w_sync_q;
        r_rise  <= w_sync_q;
        r_fall  <= ~w_sync_q;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_clean    = r_clean;
  assign o_rise     = r_rise;
  assign o_fall     = r_fall;
  assign o_cnt_zero = (r_cnt == '0);
endmodule

// File: rtl/sw_debounce.sv
// Debounces WIDTH slide switches and emits per-bit rise/fall plus combined change strobes.
// Latency SYNC_STAGES+CNT_MAX-1 edges from first sample to clean update; no backpressure.
module sw_debounce
  import sw_debounce_pkg::*;
#(
  parameter int               WIDTH       = 2,
  parameter int               CNT_MAX     = DEBOUNCE_CNT_100MHZ_10MS,
  parameter int               SYNC_STAGES = 2,
  parameter logic [WIDTH-1:0] RST_VAL     = '0
) (
  input  logic          clk,
  input  logic          rst,
  sw_debounce_if.slave  sw_if
);
  logic [WIDTH-1:0] w_clean;
  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_fall;
  logic [WIDTH-1:0] w_cnt_zero;

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    debounce_bit #(
      .CNT_MAX    (CNT_MAX),
      .SYNC_STAGES(SYNC_STAGES),
      .RST_BIT    (RST_VAL[g])
    ) u_bit (
      .clk       (clk),
      .rst       (rst),
      .i_sw_raw  (sw_if.sw_raw[g]),
      .o_clean   (w_clean[g]),
      .o_rise    (w_rise[g]),
      .o_fall    (w_fall[g]),
      .o_cnt_zero(w_cnt_zero[g])
    );
  end

  assign sw_if.sw_clean   = w_clean;
  assign sw_if.sw_rise    = w_rise;
  assign sw_if.sw_fall    = w_fall;
  // Strobes are already registered per bit, so the OR keeps them aligned with sw_clean.
  assign sw_if.sw_changed = |(w_rise | w_fall);
  assign sw_if.stable     = &w_cnt_zero;
endmodule
